bzmusic_tune_pwm: RTL
=====================

Name: bzmusic_tune_pwm

Overview:
- Tone generator stage directly downstream of the buzzer-music sequencer FSM.
- Takes the current score word's note and octave fields and the sequencer's tune enable, and drives the piezo buzzer with a square/PWM wave at the note pitch.
- Produces a per-period tick for optional beat/envelope use.
- Pitch is derived from a fixed 12-entry period table (50 MHz clock), shifted per octave; volume is set by duty cycle.

Parameters:
- SIM_SHIFT, 0: extra right shift applied to every table period; simulation speed-up only, 0 in silicon.
- PW, 18: width of the period counter and table entries.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  tune enable from sequencer; low = silent and counter held at 0.
- clr  in  1  synchronous clear, active-high; same effect as rst but on a clock edge.
- note  in  4  0 = rest, 1..12 = C..B, 13..15 = rest.
- octave  in  2  0 = C4 octave; period shifted right by octave.
- vol  in  2  0 = mute, 1 = 12.5% duty, 2 = 25%, 3 = 50%.
- pwm_out  out  1  registered buzzer drive.
- period_tick  out  1  one-cycle pulse on the last cycle of each output period.
- busy  out  1  high while a non-rest, non-muted tone is sounding.

Behaviour:
- Reset (rst or clr): cnt=0, note_q=0, oct_q=0, vol_q=0, pwm_out=0, period_tick=0, busy=0, en_d=0. rst has priority over clr; clr has priority over everything else.
- Octave-0 period table P0 (clock cycles): C 191110, C# 180388, D 170265, D# 160705, E 151685, F 143172, F# 135139, G 127551, G# 120395, A 113636, A# 107259, B 101239.
- P = P0[note_q] >> (oct_q + SIM_SHIFT). H = P >> (4 - vol_q) for vol_q in 1..3; H = 0 for vol_q 0 or a rest.
- Input capture:
  - note/octave/vol are latched into note_q/oct_q/vol_q on the cycle en rises (en=1, en_d=0).
  - While en stays high, they are relatched only on a period wrap (cnt==P-1). Mid-period input changes never cut a cycle short, so there are no glitches.
- Counter, when en=1 and the tone is non-rest:
  - cnt increments each clock and wraps at P-1 to 0.
  - period_tick=1 on the cycle following the one with cnt==P-1 (registered).
- Rest or en=0: cnt held at 0, period_tick=0, pwm_out=0.
- pwm_out is registered: pwm_out <= en & busy_comb & (cnt < H). One cycle of latency from cnt to pin.
- busy <= en & (note_q in 1..12) & (vol_q != 0), registered.
- en falling: on the next edge cnt=0 and pwm_out=0; the latched fields are retained but unused.
- en rising on the same cycle as a field change: the new input values are captured. The first period starts at cnt=0 with pwm_out high on the following cycle.
- Octave shift: P=0 cannot occur at PW=18 with octave ≤ 3 and SIM_SHIFT ≤ 10. Implementation clamps P to a minimum of 2.
- No combinational path from inputs to outputs.
- All arithmetic is unsigned PW-bit; the table is a case ROM, not inferred memory.

Test Plan:
- rst asserted mid-tone (SIM_SHIFT=10, A, oct 0, vol 3): pwm_out, busy and period_tick drop to 0 asynchronously, without waiting for a clock edge.
- SIM_SHIFT=10, note=10 (A), octave=0, vol=3, en 0→1 -> P=110, pwm_out high 55 cycles then low 55, period_tick every 110 cycles, busy=1.
- Same setup, vol=1 -> H=13: pwm_out high 13 cycles per 110. vol=0 -> pwm_out stays 0 and busy=0 while period_tick still pulses... **No:** with vol=0 the tone is treated as muted, so cnt holds and period_tick stays 0. Check that busy=0.
- Octave 2, note=1 (C), SIM_SHIFT=10 -> P = 191110 >> 12 = 46, H = 23. Change note to 12 at cnt=10 -> the current period completes at 46 cycles, and the next period is 101239 >> 12 = 24.
- note=0 or 14 with en=1 -> pwm_out=0, busy=0, cnt=0. en dropped mid-period -> pwm_out 0 next cycle. Re-raise en -> restarts at cnt=0.
- clr pulse mid-tone -> all outputs 0 on the next edge. Tone resumes only after an en rising edge or a relatch, since the latched fields were cleared.

Source files
------------

// File: rtl/bzmusic_tune_pwm.sv
// Tone generator for the buzzer-music sequencer: converts the latched
// note/octave/volume fields into a square/PWM wave on the piezo pin,
// with a one-cycle tick at the end of every output period.
//
// A tone starts one clock after en rises. That cycle only captures the
// fields, so stale fields left over from a previous tone never reach the pin.
// While the latched tone is silent (rest or vol 0) there is no period to
// protect, so the fields are recaptured every cycle. A rest in the score
// therefore gives way to the next note without en having to toggle.
module bzmusic_tune_pwm #(
    parameter int SIM_SHIFT = 0,
    parameter int PW        = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    input  logic [1:0] vol,
    output logic       pwm_out,
    output logic       period_tick,
    output logic       busy
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [3:0]    note_q;
    logic [1:0]    oct_q, vol_q;
    logic          en_d_q;
    logic          pwm_q, pwm_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;

    logic [PW-1:0] p0, p_sh, period, high_len;
    logic [5:0]    shamt;
    logic          active, rise, run, wrap, latch;

    // Octave-0 period ROM (50 MHz clock cycles)
    always_comb begin
        p0 = '0;
        case (note_q)
            4'd1:    p0 = PW'(191110);
            4'd2:    p0 = PW'(180388);
            4'd3:    p0 = PW'(170265);
            4'd4:    p0 = PW'(160705);
            4'd5:    p0 = PW'(151685);
            4'd6:    p0 = PW'(143172);
            4'd7:    p0 = PW'(135139);
            4'd8:    p0 = PW'(127551);
            4'd9:    p0 = PW'(120395);
            4'd10:   p0 = PW'(113636);
            4'd11:   p0 = PW'(107259);
            4'd12:   p0 = PW'(101239);
            default: p0 = '0;
        endcase
    end

    // Period, high time and counter control for the latched tone
    always_comb begin
        shamt    = 6'(oct_q) + 6'(SIM_SHIFT);
        p_sh     = p0 >> shamt;
        period   = (p_sh < PW'(2)) ? PW'(2) : p_sh;
        active   = (note_q >= 4'd1) && (note_q <= 4'd12) && (vol_q != 2'd0);
        high_len = active ? (period >> (3'd4 - {1'b0, vol_q})) : '0;
        rise     = en & ~en_d_q;
        run      = en & en_d_q;
        wrap     = (cnt_q == period - PW'(1));
        latch    = rise | (run & (~active | wrap));

        cnt_d  = '0;
        pwm_d  = 1'b0;
        tick_d = 1'b0;
        busy_d = 1'b0;
        if (run && active) begin
            cnt_d  = wrap ? '0 : cnt_q + PW'(1);
            pwm_d  = (cnt_q < high_len);
            tick_d = wrap;
            busy_d = 1'b1;
        end
    end

    // State and output registers; clr acts like rst but on the clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            note_q <= '0;
            oct_q  <= '0;
            vol_q  <= '0;
            en_d_q <= 1'b0;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            note_q <= '0;
            oct_q  <= '0;
            vol_q  <= '0;
            en_d_q <= 1'b0;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            en_d_q <= en;
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
            if (latch) begin
                note_q <= note;
                oct_q  <= octave;
                vol_q  <= vol;
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign busy        = busy_q;

endmodule
